// File: rtl/ct_ciu_apb_mst_pkg.sv
// Shared definitions for CIU APB initiators: FSM encoding and timeout defaults.
package ct_ciu_apb_mst_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_mst_state_e;

    // Default number of enabled ACCESS cycles without pready before giving up.
    localparam int unsigned APB_MST_TOUT_MAX = 255;
    localparam int unsigned APB_MST_TOUT_W   = 8;

endpackage

// File: rtl/ct_ciu_apb_mst.sv
// CIU-side APB initiator: takes one request at a time, runs a single APB
// transfer to the CLINT responder, and returns read data / error.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | no transfer outstanding, request port ready when apb_clk_en=1
// SETUP  | psel high, penable low, waiting for an enabled APB cycle
// ACCESS | psel and penable high, waiting for pready or the timeout
// RESP   | response valid on the CIU side until accepted
module ct_ciu_apb_mst
    import ct_ciu_apb_mst_pkg::*;
#(
    parameter int unsigned TOUT_MAX = APB_MST_TOUT_MAX
) (
    input  logic        forever_cpuclk,
    input  logic        cpurst_b,
    input  logic        apb_clk_en,

    input  logic        ciu_apb_req_vld,
    output logic        ciu_apb_req_rdy,
    input  logic [31:0] ciu_apb_req_addr,
    input  logic        ciu_apb_req_write,
    input  logic [31:0] ciu_apb_req_wdata,
    input  logic [1:0]  ciu_apb_req_prot,

    output logic        apb_ciu_resp_vld,
    output logic [31:0] apb_ciu_resp_rdata,
    output logic        apb_ciu_resp_err,
    input  logic        ciu_apb_resp_rdy,

    output logic        psel_clint,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] paddr,
    output logic [31:0] pwdata,
    output logic [1:0]  pprot,

    input  logic [31:0] prdata_clint,
    input  logic        pready_clint,
    input  logic        perr_clint
);

    // Timeout fires on the enabled no-ready cycle that would make the count TOUT_MAX.
    localparam logic [APB_MST_TOUT_W-1:0] TOUT_LAST = APB_MST_TOUT_W'(TOUT_MAX - 1);

    apb_mst_state_e              r_state;
    apb_mst_state_e              w_nxt_state;
    logic                        r_psel;
    logic                        w_nxt_psel;
    logic                        r_penable;
    logic                        w_nxt_penable;
    logic                        r_pwrite;
    logic                        w_nxt_pwrite;
    logic [31:0]                 r_paddr;
    logic [31:0]                 w_nxt_paddr;
    logic [31:0]                 r_pwdata;
    logic [31:0]                 w_nxt_pwdata;
    logic [1:0]                  r_pprot;
    logic [1:0]                  w_nxt_pprot;
    logic                        r_resp_vld;
    logic                        w_nxt_resp_vld;
    logic [31:0]                 r_resp_rdata;
    logic [31:0]                 w_nxt_resp_rdata;
    logic                        r_resp_err;
    logic                        w_nxt_resp_err;
    logic [APB_MST_TOUT_W-1:0]   r_tout_cnt;
    logic [APB_MST_TOUT_W-1:0]   w_nxt_tout_cnt;

    logic                        w_req_rdy;
    logic                        w_req_acc;
    logic                        w_addr_aligned;
    logic                        w_tout_hit;

    assign w_req_rdy      = (r_state == ST_IDLE) & apb_clk_en;
    assign w_req_acc      = ciu_apb_req_vld & w_req_rdy;
    assign w_addr_aligned = (ciu_apb_req_addr[1:0] == 2'b00);
    assign w_tout_hit     = (r_tout_cnt == TOUT_LAST);

    // State register and all registered APB / response outputs.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_state      <= ST_IDLE;
            r_psel       <= 1'b0;
            r_penable    <= 1'b0;
            r_pwrite     <= 1'b0;
            r_paddr      <= 32'd0;
            r_pwdata     <= 32'd0;
            r_pprot      <= 2'd0;
            r_resp_vld   <= 1'b0;
            r_resp_rdata <= 32'd0;
            r_resp_err   <= 1'b0;
            r_tout_cnt   <= '0;
        end else begin
            r_state      <= w_nxt_state;
            r_psel       <= w_nxt_psel;
            r_penable    <= w_nxt_penable;
            r_pwrite     <= w_nxt_pwrite;
            r_paddr      <= w_nxt_paddr;
            r_pwdata     <= w_nxt_pwdata;
            r_pprot      <= w_nxt_pprot;
            r_resp_vld   <= w_nxt_resp_vld;
            r_resp_rdata <= w_nxt_resp_rdata;
            r_resp_err   <= w_nxt_resp_err;
            r_tout_cnt   <= w_nxt_tout_cnt;
        end
    end

    // Next-state and next-output decode; everything holds unless a transition says otherwise.
    always_comb begin
        w_nxt_state      = r_state;
        w_nxt_psel       = r_psel;
        w_nxt_penable    = r_penable;
        w_nxt_pwrite     = r_pwrite;
        w_nxt_paddr      = r_paddr;
        w_nxt_pwdata     = r_pwdata;
        w_nxt_pprot      = r_pprot;
        w_nxt_resp_vld   = r_resp_vld;
        w_nxt_resp_rdata = r_resp_rdata;
        w_nxt_resp_err   = r_resp_err;
        w_nxt_tout_cnt   = r_tout_cnt;

        case (r_state)
            ST_IDLE: begin
                if (w_req_acc) begin
                    if (w_addr_aligned) begin
                        w_nxt_state   = ST_SETUP;
                        w_nxt_psel    = 1'b1;
                        w_nxt_penable = 1'b0;
                        w_nxt_paddr   = ciu_apb_req_addr;
                        w_nxt_pwrite  = ciu_apb_req_write;
                        w_nxt_pwdata  = ciu_apb_req_wdata;
                        w_nxt_pprot   = ciu_apb_req_prot;
                    end else begin
                        // Misaligned: answer with an error without touching the bus.
                        w_nxt_state      = ST_RESP;
                        w_nxt_resp_vld   = 1'b1;
                        w_nxt_resp_err   = 1'b1;
                        w_nxt_resp_rdata = 32'd0;
                    end
                end
            end
            ST_SETUP: begin
                if (apb_clk_en) begin
                    w_nxt_state    = ST_ACCESS;
                    w_nxt_penable  = 1'b1;
                    w_nxt_tout_cnt = '0;
                end
            end
            ST_ACCESS: begin
                if (apb_clk_en) begin
                    if (pready_clint) begin
                        w_nxt_state      = ST_RESP;
                        w_nxt_psel       = 1'b0;
                        w_nxt_penable    = 1'b0;
                        w_nxt_resp_vld   = 1'b1;
                        w_nxt_resp_err   = perr_clint;
                        w_nxt_resp_rdata = r_pwrite ? 32'd0 : prdata_clint;
                    end else if (w_tout_hit) begin
                        w_nxt_state      = ST_RESP;
                        w_nxt_psel       = 1'b0;
                        w_nxt_penable    = 1'b0;
                        w_nxt_resp_vld   = 1'b1;
                        w_nxt_resp_err   = 1'b1;
                        w_nxt_resp_rdata = 32'd0;
                    end else begin
                        w_nxt_tout_cnt = r_tout_cnt + 1'b1;
                    end
                end
            end
            ST_RESP: begin
                if (ciu_apb_resp_rdy) begin
                    w_nxt_state    = ST_IDLE;
                    w_nxt_resp_vld = 1'b0;
                end
            end
            default: begin
                w_nxt_state = ST_IDLE;
            end
        endcase
    end

    assign ciu_apb_req_rdy    = w_req_rdy;
    assign apb_ciu_resp_vld   = r_resp_vld;
    assign apb_ciu_resp_rdata = r_resp_rdata;
    assign apb_ciu_resp_err   = r_resp_err;
    assign psel_clint         = r_psel;
    assign penable            = r_penable;
    assign pwrite             = r_pwrite;
    assign paddr              = r_paddr;
    assign pwdata             = r_pwdata;
    assign pprot              = r_pprot;

endmodule

// File: tb/tb_ct_ciu_apb_mst.sv
// Directed bench for the CIU APB initiator.
module tb_ct_ciu_apb_mst;

    logic        forever_cpuclk;
    logic        cpurst_b;
    logic        apb_clk_en;
    logic        ciu_apb_req_vld;
    logic        ciu_apb_req_rdy;
    logic [31:0] ciu_apb_req_addr;
    logic        ciu_apb_req_write;
    logic [31:0] ciu_apb_req_wdata;
    logic [1:0]  ciu_apb_req_prot;
    logic        apb_ciu_resp_vld;
    logic [31:0] apb_ciu_resp_rdata;
    logic        apb_ciu_resp_err;
    logic        ciu_apb_resp_rdy;
    logic        psel_clint;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [1:0]  pprot;
    logic [31:0] prdata_clint;
    logic        pready_clint;
    logic        perr_clint;

    int checks   = 0;
    int failures = 0;

    ct_ciu_apb_mst dut (
        .forever_cpuclk     (forever_cpuclk),
        .cpurst_b           (cpurst_b),
        .apb_clk_en         (apb_clk_en),
        .ciu_apb_req_vld    (ciu_apb_req_vld),
        .ciu_apb_req_rdy    (ciu_apb_req_rdy),
        .ciu_apb_req_addr   (ciu_apb_req_addr),
        .ciu_apb_req_write  (ciu_apb_req_write),
        .ciu_apb_req_wdata  (ciu_apb_req_wdata),
        .ciu_apb_req_prot   (ciu_apb_req_prot),
        .apb_ciu_resp_vld   (apb_ciu_resp_vld),
        .apb_ciu_resp_rdata (apb_ciu_resp_rdata),
        .apb_ciu_resp_err   (apb_ciu_resp_err),
        .ciu_apb_resp_rdy   (ciu_apb_resp_rdy),
        .psel_clint         (psel_clint),
        .penable            (penable),
        .pwrite             (pwrite),
        .paddr              (paddr),
        .pwdata             (pwdata),
        .pprot              (pprot),
        .prdata_clint       (prdata_clint),
        .pready_clint       (pready_clint),
        .perr_clint         (perr_clint)
    );

    initial forever_cpuclk = 1'b0;
    always #5 forever_cpuclk = ~forever_cpuclk;

    task automatic tick();
        @(posedge forever_cpuclk);
        #1;
    endtask

    task automatic drive_req(input logic [31:0] addr, input logic wr,
                             input logic [31:0] wdata, input logic [1:0] prot);
        ciu_apb_req_vld   = 1'b1;
        ciu_apb_req_addr  = addr;
        ciu_apb_req_write = wr;
        ciu_apb_req_wdata = wdata;
        ciu_apb_req_prot  = prot;
    endtask

    task automatic test_reset();
        cpurst_b = 1'b0;
        apb_clk_en = 1'b0;
        ciu_apb_req_vld = 1'b0;
        ciu_apb_req_addr = 32'd0;
        ciu_apb_req_write = 1'b0;
        ciu_apb_req_wdata = 32'd0;
        ciu_apb_req_prot = 2'd0;
        ciu_apb_resp_rdy = 1'b0;
        prdata_clint = 32'd0;
        pready_clint = 1'b0;
        perr_clint = 1'b0;
        tick();
        tick();
        checks++;
        if ({psel_clint, penable, pwrite, paddr, pwdata, pprot} !== 69'd0) begin
            failures++;
            $display("FAIL reset_apb got psel=%b pen=%b pwr=%b paddr=%h pwdata=%h pprot=%b exp all 0",
                     psel_clint, penable, pwrite, paddr, pwdata, pprot);
        end
        checks++;
        if ({apb_ciu_resp_vld, apb_ciu_resp_rdata, apb_ciu_resp_err} !== 34'd0) begin
            failures++;
            $display("FAIL reset_resp got vld=%b rdata=%h err=%b exp 0",
                     apb_ciu_resp_vld, apb_ciu_resp_rdata, apb_ciu_resp_err);
        end
        #2 cpurst_b = 1'b1;
        tick();
        checks++;
        if (ciu_apb_req_rdy !== 1'b0) begin
            failures++;
            $display("FAIL req_rdy_en0 got=%b exp=0", ciu_apb_req_rdy);
        end
        apb_clk_en = 1'b1;
        #1;
        checks++;
        if (ciu_apb_req_rdy !== 1'b1) begin
            failures++;
            $display("FAIL req_rdy_en1 got=%b exp=1", ciu_apb_req_rdy);
        end
        tick();
    endtask

    task automatic test_read_min_latency();
        apb_clk_en = 1'b1;
        pready_clint = 1'b1;
        prdata_clint = 32'h1234_5678;
        perr_clint = 1'b0;
        ciu_apb_resp_rdy = 1'b1;
        drive_req(32'h0400_4000, 1'b0, 32'h0, 2'b01);
        #1;
        tick();
        ciu_apb_req_vld = 1'b0;
        checks++;
        if ({psel_clint, penable, apb_ciu_resp_vld} !== 3'b100 || paddr !== 32'h0400_4000 || pprot !== 2'b01) begin
            failures++;
            $display("FAIL rd_setup got psel=%b pen=%b vld=%b paddr=%h pprot=%b exp 1 0 0 04004000 01",
                     psel_clint, penable, apb_ciu_resp_vld, paddr, pprot);
        end
        tick();
        checks++;
        if ({psel_clint, penable, apb_ciu_resp_vld} !== 3'b110) begin
            failures++;
            $display("FAIL rd_access got psel=%b pen=%b vld=%b exp 1 1 0",
                     psel_clint, penable, apb_ciu_resp_vld);
        end
        tick();
        checks++;
        if (apb_ciu_resp_vld !== 1'b1 || apb_ciu_resp_rdata !== 32'h1234_5678 || apb_ciu_resp_err !== 1'b0
            || psel_clint !== 1'b0 || penable !== 1'b0) begin
            failures++;
            $display("FAIL rd_resp got vld=%b rdata=%h err=%b psel=%b pen=%b exp 1 12345678 0 0 0",
                     apb_ciu_resp_vld, apb_ciu_resp_rdata, apb_ciu_resp_err, psel_clint, penable);
        end
        pready_clint = 1'b0;
        tick();
        checks++;
        if (apb_ciu_resp_vld !== 1'b0 || ciu_apb_req_rdy !== 1'b1) begin
            failures++;
            $display("FAIL rd_idle got vld=%b req_rdy=%b exp 0 1", apb_ciu_resp_vld, ciu_apb_req_rdy);
        end
    endtask

    task automatic test_write_wait_en_toggle();
        int n_en = 0;
        int cyc = 0;
        int bad = 0;
        bit got = 0;
        bit seen_pen = 0;
        apb_clk_en = 1'b1;
        pready_clint = 1'b0;
        ciu_apb_resp_rdy = 1'b1;
        prdata_clint = 32'hFFFF_FFFF;
        drive_req(32'h0400_0000, 1'b1, 32'hDEAD_BEEF, 2'b10);
        tick();
        ciu_apb_req_vld = 1'b0;
        while (!got && cyc < 60) begin
            if (apb_ciu_resp_vld === 1'b1) begin
                got = 1;
            end else begin
                if (psel_clint !== 1'b1 || paddr !== 32'h0400_0000 || pwdata !== 32'hDEAD_BEEF
                    || pwrite !== 1'b1 || pprot !== 2'b10)
                    bad++;
                if (seen_pen && penable !== 1'b1)
                    bad++;
                if (penable === 1'b1)
                    seen_pen = 1;
                apb_clk_en = ~apb_clk_en;
                if (penable === 1'b1 && apb_clk_en) begin
                    n_en++;
                    pready_clint = (n_en == 3);
                end else begin
                    pready_clint = 1'b0;
                end
                tick();
                cyc++;
            end
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL wr_resp_timeout got no resp after %0d cycles", cyc);
        end
        checks++;
        if (bad != 0 || !seen_pen) begin
            failures++;
            $display("FAIL wr_stable got bad=%0d seen_pen=%0d exp 0 1", bad, seen_pen);
        end
        checks++;
        if (n_en != 3 || apb_ciu_resp_rdata !== 32'd0 || apb_ciu_resp_err !== 1'b0 || psel_clint !== 1'b0) begin
            failures++;
            $display("FAIL wr_result got n_en=%0d rdata=%h err=%b psel=%b exp 3 0 0 0",
                     n_en, apb_ciu_resp_rdata, apb_ciu_resp_err, psel_clint);
        end
        pready_clint = 1'b0;
        apb_clk_en = 1'b1;
        tick();
    endtask

    task automatic test_misaligned();
        apb_clk_en = 1'b1;
        ciu_apb_resp_rdy = 1'b0;
        pready_clint = 1'b1;
        prdata_clint = 32'hA5A5_A5A5;
        drive_req(32'h0400_0002, 1'b0, 32'h0, 2'b00);
        #1;
        checks++;
        if (ciu_apb_req_rdy !== 1'b1) begin
            failures++;
            $display("FAIL mis_rdy got=%b exp=1", ciu_apb_req_rdy);
        end
        tick();
        ciu_apb_req_vld = 1'b0;
        checks++;
        if (apb_ciu_resp_vld !== 1'b1 || apb_ciu_resp_err !== 1'b1 || apb_ciu_resp_rdata !== 32'd0
            || psel_clint !== 1'b0) begin
            failures++;
            $display("FAIL mis_resp got vld=%b err=%b rdata=%h psel=%b exp 1 1 0 0",
                     apb_ciu_resp_vld, apb_ciu_resp_err, apb_ciu_resp_rdata, psel_clint);
        end
        tick();
        checks++;
        if (psel_clint !== 1'b0 || apb_ciu_resp_vld !== 1'b1) begin
            failures++;
            $display("FAIL mis_hold got psel=%b vld=%b exp 0 1", psel_clint, apb_ciu_resp_vld);
        end
        ciu_apb_resp_rdy = 1'b1;
        tick();
        checks++;
        if (apb_ciu_resp_vld !== 1'b0 || psel_clint !== 1'b0) begin
            failures++;
            $display("FAIL mis_done got vld=%b psel=%b exp 0 0", apb_ciu_resp_vld, psel_clint);
        end
        pready_clint = 1'b0;
    endtask

    // ready_at: enabled ACCESS cycle on which pready goes high, 0 for never.
    task automatic run_timeout(input int ready_at, input logic [31:0] rd,
                               output int n_en, output bit got);
        int cyc = 0;
        n_en = 0;
        got = 0;
        apb_clk_en = 1'b1;
        pready_clint = 1'b0;
        perr_clint = 1'b0;
        prdata_clint = rd;
        ciu_apb_resp_rdy = 1'b1;
        drive_req(32'h0400_1000, 1'b0, 32'h0, 2'b00);
        tick();
        ciu_apb_req_vld = 1'b0;
        tick();
        while (!got && cyc < 600) begin
            if (apb_ciu_resp_vld === 1'b1) begin
                got = 1;
            end else begin
                apb_clk_en = ((cyc % 4) != 3);
                if (apb_clk_en) begin
                    n_en++;
                    pready_clint = (ready_at != 0) && (n_en == ready_at);
                end else begin
                    pready_clint = 1'b0;
                end
                tick();
                cyc++;
            end
        end
        pready_clint = 1'b0;
        apb_clk_en = 1'b1;
    endtask

    task automatic test_timeout();
        int n_en;
        bit got;
        run_timeout(0, 32'h1111_2222, n_en, got);
        checks++;
        if (!got || n_en != 255) begin
            failures++;
            $display("FAIL tout_count got resp=%0d enabled_cycles=%0d exp 1 255", got, n_en);
        end
        checks++;
        if (apb_ciu_resp_err !== 1'b1 || apb_ciu_resp_rdata !== 32'd0 || psel_clint !== 1'b0 || penable !== 1'b0) begin
            failures++;
            $display("FAIL tout_resp got err=%b rdata=%h psel=%b pen=%b exp 1 0 0 0",
                     apb_ciu_resp_err, apb_ciu_resp_rdata, psel_clint, penable);
        end
        tick();
        run_timeout(255, 32'hCAFE_F00D, n_en, got);
        checks++;
        if (!got || n_en != 255 || apb_ciu_resp_err !== 1'b0 || apb_ciu_resp_rdata !== 32'hCAFE_F00D) begin
            failures++;
            $display("FAIL tout_ready_prio got resp=%0d n_en=%0d err=%b rdata=%h exp 1 255 0 cafef00d",
                     got, n_en, apb_ciu_resp_err, apb_ciu_resp_rdata);
        end
        tick();
    endtask

    task automatic test_reset_mid_access();
        int cyc = 0;
        apb_clk_en = 1'b1;
        pready_clint = 1'b0;
        ciu_apb_resp_rdy = 1'b1;
        drive_req(32'h0400_0010, 1'b1, 32'h5555_AAAA, 2'b11);
        tick();
        ciu_apb_req_vld = 1'b0;
        tick();
        tick();
        tick();
        checks++;
        if ({psel_clint, penable} !== 2'b11) begin
            failures++;
            $display("FAIL rst_pre_access got psel=%b pen=%b exp 1 1", psel_clint, penable);
        end
        #2 cpurst_b = 1'b0;
        #1;
        checks++;
        if ({psel_clint, penable, pwrite, paddr, pwdata, pprot, apb_ciu_resp_vld, apb_ciu_resp_rdata, apb_ciu_resp_err} !== 104'd0) begin
            failures++;
            $display("FAIL rst_async got psel=%b pen=%b pwr=%b paddr=%h pwdata=%h pprot=%b vld=%b rdata=%h err=%b exp all 0",
                     psel_clint, penable, pwrite, paddr, pwdata, pprot, apb_ciu_resp_vld, apb_ciu_resp_rdata, apb_ciu_resp_err);
        end
        @(negedge forever_cpuclk);
        cpurst_b = 1'b1;
        tick();
        tick();
        checks++;
        if (apb_ciu_resp_vld !== 1'b0 || ciu_apb_req_rdy !== 1'b1) begin
            failures++;
            $display("FAIL rst_no_resp got vld=%b req_rdy=%b exp 0 1", apb_ciu_resp_vld, ciu_apb_req_rdy);
        end
        pready_clint = 1'b1;
        prdata_clint = 32'h0BAD_CAFE;
        drive_req(32'h0400_0014, 1'b0, 32'h0, 2'b00);
        tick();
        ciu_apb_req_vld = 1'b0;
        while (apb_ciu_resp_vld !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        checks++;
        if (apb_ciu_resp_vld !== 1'b1 || apb_ciu_resp_rdata !== 32'h0BAD_CAFE || apb_ciu_resp_err !== 1'b0) begin
            failures++;
            $display("FAIL rst_after_read got vld=%b rdata=%h err=%b exp 1 0badcafe 0",
                     apb_ciu_resp_vld, apb_ciu_resp_rdata, apb_ciu_resp_err);
        end
        pready_clint = 1'b0;
        tick();
    endtask

    task automatic test_resp_hold();
        int bad = 0;
        apb_clk_en = 1'b1;
        pready_clint = 1'b1;
        perr_clint = 1'b0;
        prdata_clint = 32'h8765_4321;
        ciu_apb_resp_rdy = 1'b0;
        drive_req(32'h0400_0020, 1'b0, 32'h0, 2'b00);
        tick();
        ciu_apb_req_vld = 1'b0;
        tick();
        tick();
        prdata_clint = 32'h0;
        perr_clint = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (apb_ciu_resp_vld !== 1'b1 || apb_ciu_resp_rdata !== 32'h8765_4321
                || apb_ciu_resp_err !== 1'b0 || ciu_apb_req_rdy !== 1'b0)
                bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL hold_stable got bad_cycles=%0d exp 0 (vld=%b rdata=%h err=%b req_rdy=%b)",
                     bad, apb_ciu_resp_vld, apb_ciu_resp_rdata, apb_ciu_resp_err, ciu_apb_req_rdy);
        end
        ciu_apb_resp_rdy = 1'b1;
        tick();
        checks++;
        if (apb_ciu_resp_vld !== 1'b0 || ciu_apb_req_rdy !== 1'b1) begin
            failures++;
            $display("FAIL hold_release got vld=%b req_rdy=%b exp 0 1", apb_ciu_resp_vld, ciu_apb_req_rdy);
        end
        pready_clint = 1'b0;
        perr_clint = 1'b0;
    endtask

    initial begin
        test_reset();
        test_read_min_latency();
        test_write_wait_en_toggle();
        test_misaligned();
        test_timeout();
        test_reset_mid_access();
        test_resp_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
